// File: rtl/ecko_pkg.sv
// ecko_pkg
// Shared defaults and state encoding for the max_unpool1d block.
//   DEF_DATA_W : default sample width
//   DEF_STRIDE : default number of output samples per pooled input sample
//   state_e    : ST_IDLE (nothing held) / ST_EMIT (held sample being expanded)
package ecko_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_STRIDE = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage : ecko_pkg

// File: rtl/max_unpool1d.sv
// max_unpool1d
// Expands each pooled input sample into STRIDE output samples.
//
// Build option (compile-time macro MAX_UNPOOL_IDX_EN):
//   undefined : every one of the STRIDE outputs repeats the held sample
//               (nearest-neighbour replication); in_idx is ignored.
//   defined   : only the output whose position equals the held in_idx
//               carries the sample, all other positions are zero. An index
//               >= STRIDE yields an all-zero window.
//
// Parameters
//   DATA_W : sample width
//   STRIDE : outputs per input sample (>= 1)
//   IDX_W  : width of in_idx (>= clog2(STRIDE), minimum 1)
//
// Ports
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   in_data   : pooled sample (unsigned)
//   in_idx    : argmax position of the sample within its window
//   in_last   : final pooled sample of a frame
//   in_valid  : upstream valid
//   in_ready  : upstream ready (combinational from out_ready while emitting)
//   out_data  : expanded sample
//   out_last  : final expanded sample of a frame
//   out_valid : downstream valid
//   out_ready : downstream ready
module max_unpool1d
  import ecko_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int STRIDE = DEF_STRIDE,
  parameter int IDX_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  // A one-bit counter is kept even for STRIDE=1; it simply stays at 0.
  localparam int                CNT_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(STRIDE - 1);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;

  logic                w_at_end;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_sel;

  assign w_at_end   = (r_cnt == LAST_CNT);
  assign out_valid  = (r_state == ST_EMIT);
  assign w_out_xfer = out_valid && out_ready;

  // Accept a new sample while idle, or on the very cycle the last beat of
  // the current window leaves, so windows stream back-to-back.
  assign in_ready   = (r_state == ST_IDLE) || (out_ready && w_at_end);
  assign w_in_xfer  = in_valid && in_ready;

`ifdef MAX_UNPOOL_IDX_EN
  logic [IDX_W-1:0]    r_idx;

  // Positions only run 0..STRIDE-1, so an out-of-range index never matches.
  assign w_sel = (32'(r_idx) == 32'(r_cnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_in_xfer) begin
      r_idx <= in_idx;
    end
  end
`else
  logic                w_unused_idx;

  assign w_unused_idx = ^in_idx;
  assign w_sel        = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_xfer) begin
            r_data  <= in_data;
            r_last  <= in_last;
            r_cnt   <= '0;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_in_xfer) begin
            // Last beat leaves and the next sample loads in the same cycle.
            r_data  <= in_data;
            r_last  <= in_last;
            r_cnt   <= '0;
          end else if (w_out_xfer) begin
            if (w_at_end) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are gated by the state so they read zero whenever nothing is held.
  assign out_data = (out_valid && w_sel) ? r_data : '0;
  assign out_last = out_valid && r_last && w_at_end;

endmodule : max_unpool1d

// File: tb/tb_max_unpool1d.sv
// tb_max_unpool1d
// Three instances: inst0 STRIDE=2/IDX_W=2, inst1 STRIDE=1/IDX_W=1,
// inst2 STRIDE=4/IDX_W=2. A window-level model predicts every output beat;
// directed vectors pin the model with hand-computed literals.
// Build option mirrored from the design: MAX_UNPOOL_IDX_EN.
module tb_max_unpool1d;

  localparam int NI = 3;
`ifdef MAX_UNPOOL_IDX_EN
  localparam bit IDX_MODE = 1'b1;
`else
  localparam bit IDX_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data   [NI];
  logic [1:0]  in_idx    [NI];
  logic        in_last   [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [15:0] out_data  [NI];
  logic        out_last  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int S  = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
    localparam int IW = (gi == 1) ? 1 : 2;
    max_unpool1d #(.DATA_W(16), .STRIDE(S), .IDX_W(IW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data[gi]),
      .in_idx    (in_idx[gi][IW-1:0]),
      .in_last   (in_last[gi]),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .out_data  (out_data[gi]),
      .out_last  (out_last[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi])
    );
  end

  function automatic int stride_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  typedef struct { logic [15:0] d; logic l; } beat_t;
  typedef struct { logic [15:0] d; logic l; int cyc; } rec_t;

  beat_t exp_q   [NI][$];
  rec_t  out_log [NI][$];
  int    in_log  [NI][$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Window-level model: every accepted input becomes STRIDE expected beats;
  // the DUT must present them in order, be valid exactly while beats are
  // pending, and accept input only when nothing or just the final beat remains.
  always @(negedge clk) begin : p_cmp
    beat_t b;
    logic  want_rdy;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        exp_q[i].delete();
        continue;
      end
      chk($sformatf("valid_inst%0d", i), 32'(out_valid[i]), 32'(exp_q[i].size() > 0));
      want_rdy = (exp_q[i].size() == 0) || (out_ready[i] && exp_q[i].size() == 1);
      chk($sformatf("ready_inst%0d", i), 32'(in_ready[i]), 32'(want_rdy));
      if (out_valid[i] && out_ready[i]) begin
        if (exp_q[i].size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_out_inst%0d: got 0x%0h, expected no output (cycle %0d)",
                   i, out_data[i], cyc);
        end else begin
          b = exp_q[i].pop_front();
          chk($sformatf("data_inst%0d", i), 32'(out_data[i]), 32'(b.d));
          chk($sformatf("last_inst%0d", i), 32'(out_last[i]), 32'(b.l));
        end
        out_log[i].push_back('{d: out_data[i], l: out_last[i], cyc: cyc});
      end
      if (in_valid[i] && in_ready[i]) begin
        in_log[i].push_back(cyc);
        for (int k = 0; k < stride_of(i); k++) begin
          b.d = (!IDX_MODE || k == int'(in_idx[i])) ? in_data[i] : 16'h0;
          b.l = in_last[i] && (k == stride_of(i) - 1);
          exp_q[i].push_back(b);
        end
      end
    end
  end

  // Called right after a rising edge; returns right after the accepting edge.
  task automatic send(int i, logic [15:0] d, logic [1:0] x, logic l);
    bit acc = 1'b0;
    in_data[i] = d; in_idx[i] = x; in_last[i] = l; in_valid[i] = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready[i]) acc = 1'b1;
    end
    if (!acc) begin
      vectors++; errors++;
      $display("FAIL send_timeout_inst%0d: got in_ready=0, expected 1 within 50 cycles", i);
    end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_log(int i, int n);
    for (int c = 0; c < 40 && out_log[i].size() < n; c++) @(negedge clk);
    chk($sformatf("beats_inst%0d", i), 32'(out_log[i].size()), 32'(n));
  endtask

  task automatic chk_log(int i, int k, logic [15:0] d, logic l);
    if (out_log[i].size() > k) begin
      chk($sformatf("lit_data_inst%0d_beat%0d", i, k), 32'(out_log[i][k].d), 32'(d));
      chk($sformatf("lit_last_inst%0d_beat%0d", i, k), 32'(out_log[i][k].l), 32'(l));
    end else begin
      vectors++; errors++;
      $display("FAIL lit_missing_inst%0d_beat%0d: got %0d beats, expected > %0d",
               i, k, out_log[i].size(), k);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) begin
      out_log[i].delete();
      in_log[i].delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_data[i] = '0; in_idx[i] = '0; in_last[i] = 1'b0;
      in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    end
    #3;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid_inst%0d", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("rst_data_inst%0d", i),  32'(out_data[i]),  32'd0);
      chk($sformatf("rst_last_inst%0d", i),  32'(out_last[i]),  32'd0);
      chk($sformatf("rst_ready_inst%0d", i), 32'(in_ready[i]),  32'd1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back stream on STRIDE=2, no bubble.
    clear_logs();
    send(0, 16'h0005, 2'd0, 1'b0);
    send(0, 16'h0009, 2'd1, 1'b1);
    wait_log(0, 4);
    chk_log(0, 0, 16'h0005, 1'b0);
    chk_log(0, 1, IDX_MODE ? 16'h0000 : 16'h0005, 1'b0);
    chk_log(0, 2, IDX_MODE ? 16'h0000 : 16'h0009, 1'b0);
    chk_log(0, 3, 16'h0009, 1'b1);
    if (out_log[0].size() >= 4 && in_log[0].size() >= 2) begin
      chk("b2b_latency",  32'(out_log[0][0].cyc - in_log[0][0]), 32'd1);
      chk("b2b_span",     32'(out_log[0][3].cyc - out_log[0][0].cyc), 32'd3);
      chk("b2b_reload",   32'(in_log[0][1] - in_log[0][0]), 32'd2);
    end
    @(posedge clk); #1;

    // STRIDE=4 windows.
    clear_logs();
    send(2, 16'h00A0, 2'd2, 1'b0);
    send(2, 16'h0007, 2'd3, 1'b1);
    wait_log(2, 8);
    for (int k = 0; k < 4; k++)
      chk_log(2, k, (!IDX_MODE || k == 2) ? 16'h00A0 : 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++)
      chk_log(2, 4 + k, (!IDX_MODE || k == 3) ? 16'h0007 : 16'h0000, k == 3);
    @(posedge clk); #1;

    // Backpressure on STRIDE=2.
    out_ready[0] = 1'b0;
    send(0, 16'h1234, 2'd0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_data",  32'(out_data[0]),  32'h1234);
      chk("bp_last",  32'(out_last[0]),  32'd0);
      chk("bp_ready", 32'(in_ready[0]),  32'd0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_beat0_data",  32'(out_data[0]), 32'h1234);
    chk("bp_beat0_ready", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    chk("bp_beat1_data",  32'(out_data[0]), IDX_MODE ? 32'h0 : 32'h1234);
    chk("bp_beat1_last",  32'(out_last[0]), 32'd1);
    chk("bp_beat1_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a window.
    send(0, 16'h00FF, 2'd0, 1'b0);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid[0]), 32'd0);
    chk("arst_data",  32'(out_data[0]),  32'd0);
    chk("arst_ready", 32'(in_ready[0]),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    clear_logs();
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid[0]), 32'd0);
      chk("post_rst_ready", 32'(in_ready[0]),  32'd1);
    end
    chk("post_rst_beats", 32'(out_log[0].size()), 32'd0);
    @(posedge clk); #1;

    // STRIDE=1 pass-through.
    clear_logs();
    send(1, 16'h0001, 2'd0, 1'b0);
    send(1, 16'h0002, 2'd0, 1'b0);
    send(1, 16'h0003, 2'd0, 1'b1);
    wait_log(1, 3);
    chk_log(1, 0, 16'h0001, 1'b0);
    chk_log(1, 1, 16'h0002, 1'b0);
    chk_log(1, 2, 16'h0003, 1'b1);
    if (out_log[1].size() >= 3 && in_log[1].size() >= 1) begin
      chk("s1_latency", 32'(out_log[1][0].cyc - in_log[1][0]), 32'd1);
      chk("s1_span",    32'(out_log[1][2].cyc - out_log[1][0].cyc), 32'd2);
    end
    @(posedge clk); #1;

    // Out-of-range index on STRIDE=2.
    clear_logs();
    send(0, 16'h0011, 2'd3, 1'b1);
    wait_log(0, 2);
    chk_log(0, 0, IDX_MODE ? 16'h0000 : 16'h0011, 1'b0);
    chk_log(0, 1, IDX_MODE ? 16'h0000 : 16'h0011, 1'b1);
    @(negedge clk);
    chk("oor_idle_valid", 32'(out_valid[0]), 32'd0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("drained_inst%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_max_unpool1d
